// File: rtl/ac_inverse_gen_pkg.sv
// Shared constants for the haze-removal pipeline: fixed-point widths, the
// haze-retention factor and the inverse-generator FSM encoding.
package ac_inverse_gen_pkg;

    localparam int Q16_W = 16;
    localparam int PIX_W = 8;

    // omega = 0.9 in Q0.16
    localparam logic [Q16_W-1:0] HAZE_OMEGA_Q16 = 16'd58982;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIV   = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/serial_divider_u16_u8.sv
// Restoring serial divider: unsigned DIV_BITS-bit dividend by 8-bit divisor,
// one quotient bit per cycle, MSB first.
module serial_divider_u16_u8
    import ac_inverse_gen_pkg::*;
#(
    parameter int DIV_BITS = Q16_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DIV_BITS-1:0] dividend,
    input  logic [PIX_W-1:0]    divisor,
    output logic [DIV_BITS-1:0] quotient,
    output logic                rdy
);

    localparam int CNT_W = $clog2(DIV_BITS + 1);

    logic [DIV_BITS-1:0] rem;
    logic [DIV_BITS-1:0] quo;
    logic [PIX_W:0]      dsr;
    logic [CNT_W-1:0]    cnt;

    logic [DIV_BITS:0]   partial;
    logic [DIV_BITS:0]   diff;

    // The remainder is always below the divisor, so a negative trial shows up
    // as a set top bit of the difference; no separate comparator is needed.
    always_comb begin
        partial = {rem, quo[DIV_BITS-1]};
        diff    = partial - {{(DIV_BITS - PIX_W){1'b0}}, dsr};
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register here samples the pre-edge value of every other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dsr <= {1'b0, divisor};
            cnt <= CNT_W'(DIV_BITS);
        end else if (cnt != '0) begin
            if (!diff[DIV_BITS]) begin
                rem <= diff[DIV_BITS-1:0];
                quo <= {quo[DIV_BITS-2:0], 1'b1};
            end else begin
                rem <= partial[DIV_BITS-1:0];
                quo <= {quo[DIV_BITS-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
        end
    end

    assign quotient = quo;
    assign rdy      = (cnt == '0);

endmodule

// File: rtl/ac_inverse_gen.sv
// Per-frame generator of omega/Ac for R, G and B in Q0.16, using one shared
// serial divider and holding the results stable between updates.
module ac_inverse_gen
    import ac_inverse_gen_pkg::*;
#(
    parameter logic [Q16_W-1:0] OMEGA_Q16 = HAZE_OMEGA_Q16,
    parameter int               DIV_BITS  = Q16_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] Ac_R,
    input  logic [PIX_W-1:0] Ac_G,
    input  logic [PIX_W-1:0] Ac_B,
    output logic [Q16_W-1:0] Inv_AR,
    output logic [Q16_W-1:0] Inv_AG,
    output logic [Q16_W-1:0] Inv_AB,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(DIV_BITS);

    logic [1:0]         state;
    logic [1:0]         ch;
    logic [BIT_W-1:0]   bit_cnt;
    logic [PIX_W-1:0]   ac_r_q, ac_g_q, ac_b_q;
    logic [Q16_W-1:0]   shadow_r, shadow_g;

    logic               accept;
    logic               div_load;
    logic [PIX_W-1:0]   div_divisor;
    logic [Q16_W-1:0]   div_quot;
    logic               div_rdy;
    logic [PIX_W-1:0]   cur_ac;
    logic [Q16_W-1:0]   q_final;

    // A new request is taken in DONE as well, giving the 52-cycle cadence.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        accept      = start && (state == ST_IDLE || state == ST_DONE);
        div_load    = accept || (state == ST_STORE && div_rdy && ch != 2'd2);
        div_divisor = accept ? Ac_R : ((ch == 2'd0) ? ac_g_q : ac_b_q);
        cur_ac      = ac_b_q;
        case (ch)
            2'd0:    cur_ac = ac_r_q;
            2'd1:    cur_ac = ac_g_q;
            default: cur_ac = ac_b_q;
        endcase
        q_final = (cur_ac == '0) ? '1 : div_quot;
    end

    assign busy = (state == ST_DIV) || (state == ST_STORE);

    serial_divider_u16_u8 #(.DIV_BITS(DIV_BITS)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .dividend (OMEGA_Q16),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .rdy      (div_rdy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ch       <= 2'd0;
            bit_cnt  <= '0;
            ac_r_q   <= '0;
            ac_g_q   <= '0;
            ac_b_q   <= '0;
            shadow_r <= '0;
            shadow_g <= '0;
            Inv_AR   <= '0;
            Inv_AG   <= '0;
            Inv_AB   <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_DIV: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_W'(DIV_BITS - 1)) state <= ST_STORE;
                end
                ST_STORE: begin
                    if (div_rdy) begin
                        bit_cnt <= '0;
                        case (ch)
                            2'd0: begin
                                shadow_r <= q_final;
                                ch       <= 2'd1;
                                state    <= ST_DIV;
                            end
                            2'd1: begin
                                shadow_g <= q_final;
                                ch       <= 2'd2;
                                state    <= ST_DIV;
                            end
                            default: begin
                                // Blue goes straight to the output so all
                                // three results land on the same edge that
                                // raises done.
                                Inv_AR <= shadow_r;
                                Inv_AG <= shadow_g;
                                Inv_AB <= q_final;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                        endcase
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (accept) begin
                        ac_r_q  <= Ac_R;
                        ac_g_q  <= Ac_G;
                        ac_b_q  <= Ac_B;
                        ch      <= 2'd0;
                        bit_cnt <= '0;
                        state   <= ST_DIV;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_inverse_gen.sv
// Scoreboard bench for ac_inverse_gen: stimulus queues expected results, a
// monitor checks every done pulse, its latency and output stability.
module tb_ac_inverse_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ac_r = '0, ac_g = '0, ac_b = '0;
    logic [15:0] inv_ar, inv_ag, inv_ab;
    logic        busy, done;

    typedef struct {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        int          start_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] last_r = '0, last_g = '0, last_b = '0;

    always #5 clk = ~clk;

    ac_inverse_gen dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .Ac_R   (ac_r),
        .Ac_G   (ac_g),
        .Ac_B   (ac_b),
        .Inv_AR (inv_ar),
        .Inv_AG (inv_ag),
        .Inv_AB (inv_ab),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_inv(input logic [7:0] a);
        return (a == 8'd0) ? 16'hFFFF : 16'(32'd58982 / 32'(a));
    endfunction

    // Monitor: compares on every done pulse, otherwise checks outputs hold.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("inv_ar", 32'(inv_ar), 32'(e.r));
                check("inv_ag", 32'(inv_ag), 32'(e.g));
                check("inv_ab", 32'(inv_ab), 32'(e.b));
                check("latency", 32'(cyc - e.start_cyc), 32'd51);
                last_r = e.r;
                last_g = e.g;
                last_b = e.b;
            end
        end else begin
            check("hold_r", 32'(inv_ar), 32'(last_r));
            check("hold_g", 32'(inv_ag), 32'(last_g));
            check("hold_b", 32'(inv_ab), 32'(last_b));
        end
    end

    // Called at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [15:0] er, input logic [15:0] eg, input logic [15:0] eb);
        exp_t x;
        start = 1'b1;
        ac_r  = r;
        ac_g  = g;
        ac_b  = b;
        x.r = er;
        x.g = eg;
        x.b = eb;
        x.start_cyc = cyc + 1;
        sb_q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 32'(done), 32'd1);
            sb_q.delete();
        end
    endtask

    initial begin
        logic [7:0] r, g, b;

        repeat (3) @(negedge clk);
        check("rst_inv_ar", 32'(inv_ar), 32'd0);
        check("rst_inv_ag", 32'(inv_ag), 32'd0);
        check("rst_inv_ab", 32'(inv_ab), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal
        issue(8'd255, 8'd200, 8'd128, 16'd231, 16'd294, 16'd460);
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done();
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Boundary: divisor 1, 0 and 2
        issue(8'd1, 8'd0, 8'd2, 16'd58982, 16'd65535, 16'd29491);
        wait_done();
        repeat (2) @(negedge clk);

        // Start while busy is ignored
        issue(8'd255, 8'd200, 8'd128, 16'd231, 16'd294, 16'd460);
        repeat (9) @(negedge clk);
        start = 1'b1;
        ac_r = 8'd1;
        ac_g = 8'd1;
        ac_b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (60) @(negedge clk);

        // Back-to-back, second start in the cycle after done
        issue(8'd255, 8'd200, 8'd128, 16'd231, 16'd294, 16'd460);
        wait_done();
        issue(8'd100, 8'd50, 8'd25, 16'd589, 16'd1179, 16'd2359);
        wait_done();
        repeat (2) @(negedge clk);

        // Reset in the middle of a computation
        issue(8'd255, 8'd200, 8'd128, 16'd231, 16'd294, 16'd460);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        last_r = '0;
        last_g = '0;
        last_b = '0;
        #1;
        check("abort_inv_ar", 32'(inv_ar), 32'd0);
        check("abort_inv_ab", 32'(inv_ab), 32'd0);
        check("abort_busy",   32'(busy),   32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_done_busy", 32'(busy), 32'd0);
        issue(8'd255, 8'd200, 8'd128, 16'd231, 16'd294, 16'd460);
        wait_done();

        // Random sweep, back-to-back
        for (int i = 0; i < 1000; i++) begin
            r = 8'($urandom_range(0, 255));
            g = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            issue(r, g, b, ref_inv(r), ref_inv(g), ref_inv(b));
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
